// File: rtl/regb_fifo_lvl_if.sv
// rtl/regb_fifo_lvl_if.sv - data, handshake and status bundle for the register FIFO
interface regb_fifo_lvl_if #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] wdata;
   logic             shift_in;
   logic             shift_out;
   logic             err_clr;
   logic [WIDTH-1:0] rdata;
   logic             empty;
   logic             full;
   logic             almost_empty;
   logic             almost_full;
   logic [CW-1:0]    fill;
   logic             ovf;
   logic             udf;

   modport master (
      output wdata, shift_in, shift_out, err_clr,
      input  rdata, empty, full, almost_empty, almost_full, fill, ovf, udf
   );

   modport slave (
      input  wdata, shift_in, shift_out, err_clr,
      output rdata, empty, full, almost_empty, almost_full, fill, ovf, udf
   );
endinterface

// File: rtl/regb_fifo_lvl.sv
// rtl/regb_fifo_lvl.sv - register FIFO, packed toward the head, with level flags
// Optional sticky ovf/udf error flags are built when REGB_FIFO_ERR_EN is defined.
module regb_fifo_lvl #(
   parameter int DEPTH  = 8,
   parameter int WIDTH  = 8,
   parameter int AF_LVL = DEPTH - 2,
   parameter int AE_LVL = 2
) (
   input  logic           clk,
   input  logic           res,
   regb_fifo_lvl_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] mem_nxt [DEPTH];
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [CW-1:0]    wr_idx;
   logic             rd_acc;
   logic             wr_acc;
   logic             empty_q;
   logic             full_q;
   logic             ae_q;
   logic             af_q;

   // Slots at or beyond cnt are always zero, so mem[0] doubles as the zeroed empty rdata.
   always_comb begin
      rd_acc  = bus.shift_out && !empty_q;
      wr_acc  = bus.shift_in && (!full_q || bus.shift_out);
      wr_idx  = rd_acc ? cnt - CW'(1) : cnt;
      cnt_nxt = cnt;
      if (wr_acc && !rd_acc) begin
         cnt_nxt = cnt + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         cnt_nxt = cnt - CW'(1);
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         mem_nxt[i] = rd_acc ? mem[i+1] : mem[i];
      end
      mem_nxt[DEPTH-1] = rd_acc ? '0 : mem[DEPTH-1];
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_acc && wr_idx == CW'(i)) begin
            mem_nxt[i] = bus.wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         cnt     <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ae_q    <= 1'b1;
         af_q    <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= mem_nxt[i];
         end
         cnt     <= cnt_nxt;
         empty_q <= (cnt_nxt == '0);
         full_q  <= (cnt_nxt == CW'(DEPTH));
         ae_q    <= (int'(cnt_nxt) <= AE_LVL);
         af_q    <= (int'(cnt_nxt) >= AF_LVL);
      end
   end

   assign bus.rdata        = mem[0];
   assign bus.fill         = cnt;
   assign bus.empty        = empty_q;
   assign bus.full         = full_q;
   assign bus.almost_empty = ae_q;
   assign bus.almost_full  = af_q;

`ifdef REGB_FIFO_ERR_EN
   logic ovf_q;
   logic udf_q;

   // A fresh error in the same cycle takes priority over err_clr.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (bus.shift_in && full_q && !bus.shift_out) begin
            ovf_q <= 1'b1;
         end else if (bus.err_clr) begin
            ovf_q <= 1'b0;
         end
         if (bus.shift_out && empty_q) begin
            udf_q <= 1'b1;
         end else if (bus.err_clr) begin
            udf_q <= 1'b0;
         end
      end
   end

   assign bus.ovf = ovf_q;
   assign bus.udf = udf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.ovf        = 1'b0;
   assign bus.udf        = 1'b0;
`endif
endmodule

// File: tb/tb_regb_fifo_lvl.sv
// tb/tb_regb_fifo_lvl.sv - scoreboard bench for regb_fifo_lvl at DEPTH 4 and DEPTH 8
module tb_regb_fifo_lvl;
   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic [7:0] wdata = '0;
   logic       shift_in = 1'b0;
   logic       shift_out = 1'b0;
   logic       err_clr = 1'b0;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regb_fifo_lvl_if #(.DEPTH(4), .WIDTH(8)) b4 ();
   regb_fifo_lvl_if #(.DEPTH(8), .WIDTH(8)) b8 ();

   assign b4.wdata = wdata;  assign b4.shift_in = shift_in;
   assign b4.shift_out = shift_out;  assign b4.err_clr = err_clr;
   assign b8.wdata = wdata;  assign b8.shift_in = shift_in;
   assign b8.shift_out = shift_out;  assign b8.err_clr = err_clr;

   regb_fifo_lvl #(.DEPTH(4), .WIDTH(8)) u4 (.clk(clk), .res(res), .bus(b4.slave));
   regb_fifo_lvl #(.DEPTH(8), .WIDTH(8), .AF_LVL(6), .AE_LVL(2)) u8 (.clk(clk), .res(res), .bus(b8.slave));

   typedef struct {
      int which;
      int rdata, fill, empty, full, ae, af, ovf, udf;
   } snap_t;

   snap_t      exp_q[$];
   logic [7:0] q4[$];
   logic [7:0] q8[$];
   bit         ovf_m[2];
   bit         udf_m[2];

   function automatic snap_t mk(int k);
      snap_t      s;
      logic [7:0] q[$];
      int         d;
      q = (k == 0) ? q4 : q8;
      d = (k == 0) ? 4 : 8;
      s.which = k;
      s.rdata = (q.size() > 0) ? int'(q[0]) : 0;
      s.fill  = q.size();
      s.empty = int'(q.size() == 0);
      s.full  = int'(q.size() == d);
      s.ae    = int'(q.size() <= 2);
      s.af    = int'(q.size() >= ((k == 0) ? 2 : 6));
      s.ovf   = int'(ovf_m[k]);
      s.udf   = int'(udf_m[k]);
      return s;
   endfunction

   task automatic model_step(bit si, bit so, logic [7:0] wd, bit ec);
      for (int k = 0; k < 2; k++) begin
         logic [7:0] q[$];
         int  d, n;
         bit  rd, wr, o, u;
         q  = (k == 0) ? q4 : q8;
         d  = (k == 0) ? 4 : 8;
         n  = q.size();
         rd = so && n > 0;
         wr = si && (n < d || so);
         o  = si && n == d && !so;
         u  = so && n == 0;
         if (rd) void'(q.pop_front());
         if (wr) q.push_back(wd);
`ifdef REGB_FIFO_ERR_EN
         if (o) ovf_m[k] = 1'b1; else if (ec) ovf_m[k] = 1'b0;
         if (u) udf_m[k] = 1'b1; else if (ec) udf_m[k] = 1'b0;
`else
         if (o || u || ec) begin
            ovf_m[k] = 1'b0;
            udf_m[k] = 1'b0;
         end
`endif
         if (k == 0) q4 = q; else q8 = q;
         exp_q.push_back(mk(k));
      end
   endtask

   task automatic cycle(bit si, bit so, logic [7:0] wd, bit ec);
      @(negedge clk);
      res       = 1'b0;
      shift_in  = si;
      shift_out = so;
      wdata     = wd;
      err_clr   = ec;
      model_step(si, so, wd, ec);
   endtask

   task automatic async_reset();
      q4.delete();
      q8.delete();
      ovf_m = '{default: 1'b0};
      udf_m = '{default: 1'b0};
      exp_q.push_back(mk(0));
      exp_q.push_back(mk(1));
      res = 1'b1;
   endtask

   function automatic void cmp(string nm, int w, logic [31:0] act, int expv);
      n_vec++;
      if (act !== 32'(expv)) begin
         n_bad++;
         $display("FAIL %s depth%0d: got %0h expected %0h", nm, (w == 0) ? 4 : 8, act, expv);
      end
   endfunction

   task automatic check(snap_t e);
      if (e.which == 0) begin
         cmp("rdata", 0, 32'(b4.rdata), e.rdata);
         cmp("fill", 0, 32'(b4.fill), e.fill);
         cmp("empty", 0, 32'(b4.empty), e.empty);
         cmp("full", 0, 32'(b4.full), e.full);
         cmp("almost_empty", 0, 32'(b4.almost_empty), e.ae);
         cmp("almost_full", 0, 32'(b4.almost_full), e.af);
         cmp("ovf", 0, 32'(b4.ovf), e.ovf);
         cmp("udf", 0, 32'(b4.udf), e.udf);
      end else begin
         cmp("rdata", 1, 32'(b8.rdata), e.rdata);
         cmp("fill", 1, 32'(b8.fill), e.fill);
         cmp("empty", 1, 32'(b8.empty), e.empty);
         cmp("full", 1, 32'(b8.full), e.full);
         cmp("almost_empty", 1, 32'(b8.almost_empty), e.ae);
         cmp("almost_full", 1, 32'(b8.almost_full), e.af);
         cmp("ovf", 1, 32'(b8.ovf), e.ovf);
         cmp("udf", 1, 32'(b8.udf), e.udf);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge res);
         #1;
         while (exp_q.size() > 0) check(exp_q.pop_front());
      end
   end

   initial begin
      int pin, pout;
      #1;
      async_reset();
      repeat (2) @(posedge clk);

      for (int i = 1; i <= 4; i++) cycle(1, 0, 8'(i * 8'h11), 0);
      repeat (5) cycle(0, 1, 8'h00, 0);
      cycle(0, 0, 8'h00, 1);

      for (int i = 0; i < 4; i++) cycle(1, 0, 8'hA0 + 8'(i), 0);
      cycle(1, 0, 8'h55, 0);
      repeat (6) cycle(0, 1, 8'h00, 0);
      cycle(0, 0, 8'h00, 1);

      for (int i = 0; i < 4; i++) cycle(1, 0, 8'hB0 + 8'(i), 0);
      cycle(1, 1, 8'h77, 0);
      repeat (5) cycle(0, 1, 8'h00, 0);
      cycle(0, 0, 8'h00, 1);

      cycle(1, 1, 8'h3C, 0);
      cycle(0, 0, 8'h00, 1);
      cycle(0, 1, 8'h00, 0);

      for (int i = 0; i < 3; i++) cycle(1, 0, 8'hC0 + 8'(i), 0);
      @(negedge clk);
      shift_in  = 1'b0;
      shift_out = 1'b0;
      #2;
      async_reset();
      cycle(1, 0, 8'h99, 0);
      cycle(0, 1, 8'h00, 0);

      for (int i = 0; i < 9; i++) cycle(1, 0, 8'hD0 + 8'(i), 0);
      for (int i = 0; i < 9; i++) cycle(0, 1, 8'h00, 0);
      cycle(0, 0, 8'h00, 1);

      for (int blk = 0; blk < 12; blk++) begin
         pin  = $urandom_range(10, 90);
         pout = $urandom_range(10, 90);
         for (int i = 0; i < 40; i++) begin
            cycle($urandom_range(0, 99) < pin, $urandom_range(0, 99) < pout,
                  8'($urandom), $urandom_range(0, 15) == 0);
         end
      end

      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/regb_fifo_lvl.md
REGB_FIFO_LVL -- requirements
Module: regb_fifo_lvl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries, legal range 2..64.
REQ-002 SHALL have parameter WIDTH, default 8, data bits per entry, legal range 1..64.
REQ-003 SHALL have parameter AF_LVL, default DEPTH-2, almost_full asserts at fill >= AF_LVL, legal range 1..DEPTH.
REQ-004 SHALL have parameter AE_LVL, default 2, almost_empty asserts at fill <= AE_LVL, legal range 0..DEPTH-1.
REQ-005 SHALL have local width CW = $clog2(DEPTH+1).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 res  input  1  reset, asynchronous, active-high.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 shift_in  input  1  write request.
REQ-010 shift_out  input  1  read request; pops the current head.
REQ-011 rdata  output  WIDTH  head entry, first-word-fall-through; all-zero when empty.
REQ-012 empty, full  output  1 each  fill==0, fill==DEPTH.
REQ-013 almost_empty, almost_full  output  1 each  threshold flags per REQ-003/004.
REQ-014 fill  output  CW  current entry count.
REQ-015 ovf, udf  output  1 each  sticky overflow/underflow error flags (REQ-029).
REQ-016 err_clr  input  1  clears ovf/udf (REQ-029).

Function
REQ-017 SHALL store entries in registers only (no RAM macro); entries SHALL be kept packed toward the output end so the head is always at a fixed position feeding rdata.
REQ-018 A write SHALL be accepted when shift_in=1 and (full=0 or shift_out=1); an accepted write stores wdata behind the last valid entry.
REQ-019 A read SHALL be accepted when shift_out=1 and empty=0; the remaining entries advance one position in the same cycle.
REQ-020 Simultaneous accepted read and write SHALL leave fill unchanged; when fill==1, the written word SHALL appear on rdata the next cycle.
REQ-021 When full, shift_in with shift_out SHALL be accepted (pass-through at capacity); shift_in without shift_out SHALL be dropped, contents unchanged.
REQ-022 When empty, shift_out SHALL be ignored; a simultaneous shift_in SHALL still be accepted, fill becomes 1.
REQ-023 Write-to-rdata latency SHALL be 1 cycle into an empty FIFO; there SHALL be no combinational path from wdata/shift_in to rdata.
REQ-024 fill SHALL update +1 / -1 / 0 per accepted write/read and never leave 0..DEPTH.
REQ-025 All status flags SHALL be registered and consistent with fill in the same cycle.
REQ-026 Data order SHALL be strictly FIFO; no entry SHALL be duplicated or lost except a dropped write per REQ-021.

Reset
REQ-027 Asserting res SHALL immediately, independent of clk, empty the FIFO: fill=0, empty=1, full=0, almost_empty=1, almost_full=0, rdata=0, ovf=0, udf=0.
REQ-028 Reset mid-operation SHALL discard all contents; the first accepted write after res deasserts SHALL be the next rdata.

Configuration
REQ-029 Macro REGB_FIFO_ERR_EN: when defined, ovf SHALL set on a write dropped per REQ-021, udf SHALL set on a read ignored per REQ-022; both remain set until err_clr=1 (cleared next edge; a same-cycle error wins over err_clr). When undefined, ovf=udf=0 constantly and err_clr is ignored.

Verification
REQ-030 DEPTH=4: write 0x11,0x22,0x33,0x44 -> full=1, fill=4, almost_full=1; four reads return 0x11..0x44 in order, then empty=1, rdata=0.
REQ-031 Full FIFO 0xA0..0xA3, shift_in=1 with wdata=0x55 and shift_out=0 -> fill stays 4, next reads return 0xA0..0xA3; ovf=1 with REGB_FIFO_ERR_EN, 0 without.
REQ-032 Full FIFO, shift_in=1 and shift_out=1 with wdata=0x77 for one cycle -> fill=4, full=1, 0x77 emerges as the fourth read.
REQ-033 Empty FIFO, shift_in=1, wdata=0x3C, shift_out=1 same cycle -> next cycle fill=1, rdata=0x3C; udf=1 with REGB_FIFO_ERR_EN; err_clr pulse -> udf=0.
REQ-034 Fill=3, assert res between clock edges -> outputs at reset values before the next edge; after release write 0x99 -> rdata=0x99 one cycle later.
REQ-035 DEPTH=8, AE_LVL=2, AF_LVL=6: step fill 0..8 and back -> almost_empty=1 exactly at fill 0..2, almost_full=1 exactly at fill 6..8.
